// File: rtl/unidade_controle_mc_if.sv
// Bus between the multicycle control unit and its datapath: instruction fields
// and flags in, control strobes and selectors out.
interface unidade_controle_mc_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       pc_en;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output PCWrite, PCWriteCond, pc_en, PCSource, IorD, MemRead, MemWrite,
               IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               illegal_op, state
    );

    modport slave (
        output opcode, funct, zero,
        input  PCWrite, PCWriteCond, pc_en, PCSource, IorD, MemRead, MemWrite,
               IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               illegal_op, state
    );
endinterface

// File: rtl/unidade_controle_mc.sv
// Moore control FSM for a multicycle MIPS-subset datapath (lw, sw, R-type, jr,
// beq, bne, j, addi).
//
// state  | meaning
// FETCH  | read instruction, load IR, PC <= PC+4
// DECODE | compute branch target, dispatch on opcode
// MEMADR | effective address for lw/sw
// MEMRD  | data memory read
// MEMWB  | write MDR to rt
// MEMWR  | data memory write
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare and conditional PC update
// JUMP   | PC <= jump address
// ADDIEX | register + immediate
// ADDIWB | write ALU result to rt
// JR     | PC <= register
module unidade_controle_mc (
    input  logic                  clk,
    input  logic                  reset,
    unidade_controle_mc_if.master bus
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JR     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       op_supported;

    always_comb begin
        op_supported = 1'b0;
        case (bus.opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: op_supported = 1'b1;
            default:                                              op_supported = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE:        state_d = (bus.funct == FN_JR) ? S_JR : S_EXEC;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ADDI:         state_d = S_ADDIEX;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            // Every terminal state and the unused encodings 13-15 return to FETCH.
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, memto_reg, reg_write, alu_src_a;
    logic [1:0] pc_source, alu_src_b, alu_op;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        memto_reg     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
            end
            S_DECODE:          alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                memto_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDIWB:          reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.PCSource    = pc_source;
    assign bus.IorD        = iord;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.RegDst      = reg_dst;
    assign bus.MemtoReg    = memto_reg;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.state       = state_q;
    assign bus.illegal_op  = (state_q == S_DECODE) && !op_supported;
    // bne takes the branch when the ALU difference is non-zero.
    assign bus.pc_en       = pc_write | (pc_write_cond & (bus.zero ^ (bus.opcode == OP_BNE)));
endmodule

// File: tb/tb_unidade_controle_mc.sv
// Directed plus randomized instruction stream against a path/output model of the
// multicycle control unit.
module tb_unidade_controle_mc;
    logic clk;
    logic reset;

    unidade_controle_mc_if bus ();

    unidade_controle_mc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcsrc;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
    } ctrl_t;

    int tests = 0;
    int fails = 0;
    int path_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected control word for each named state, taken from the state descriptions.
    function automatic ctrl_t exp_ctrl(input int st);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.pcw = 1; c.mr = 1; c.irw = 1; c.srcb = 2'b01; end
            1:  c.srcb = 2'b11;
            2, 10: begin c.srca = 1; c.srcb = 2'b10; end
            3:  begin c.mr = 1; c.iord = 1; end
            4:  begin c.rw = 1; c.m2r = 1; end
            5:  begin c.mw = 1; c.iord = 1; end
            6:  begin c.srca = 1; c.aluop = 2'b10; end
            7:  begin c.rw = 1; c.rdst = 1; end
            8:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
            9:  begin c.pcw = 1; c.pcsrc = 2'b10; end
            11: c.rw = 1;
            12: begin c.pcw = 1; c.pcsrc = 2'b11; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t obs_ctrl();
        ctrl_t c;
        c.pcw   = bus.PCWrite;
        c.pcwc  = bus.PCWriteCond;
        c.pcsrc = bus.PCSource;
        c.iord  = bus.IorD;
        c.mr    = bus.MemRead;
        c.mw    = bus.MemWrite;
        c.irw   = bus.IRWrite;
        c.rdst  = bus.RegDst;
        c.m2r   = bus.MemtoReg;
        c.rw    = bus.RegWrite;
        c.srca  = bus.ALUSrcA;
        c.srcb  = bus.ALUSrcB;
        c.aluop = bus.ALUOp;
        return c;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 ||
               op == 6'h05 || op == 6'h02 || op == 6'h08;
    endfunction

    // State path of one instruction, FETCH inclusive; its length is the latency.
    function automatic void build_path(input logic [5:0] op, input logic [5:0] fn);
        path_q = {0, 1};
        if (op == 6'h23)                   path_q = {path_q, 2, 3, 4};
        else if (op == 6'h2b)              path_q = {path_q, 2, 5};
        else if (op == 6'h00 && fn == 6'h08) path_q.push_back(12);
        else if (op == 6'h00)              path_q = {path_q, 6, 7};
        else if (op == 6'h04 || op == 6'h05) path_q.push_back(8);
        else if (op == 6'h02)              path_q.push_back(9);
        else if (op == 6'h08)              path_q = {path_q, 10, 11};
    endfunction

    task automatic check_cycle(input int st, input logic [5:0] op, input logic z);
        ctrl_t e;
        logic  pc_exp;
        e = exp_ctrl(st);
        if (st == 8) pc_exp = (op == 6'h05) ? !z : z;
        else         pc_exp = e.pcw;
        check("state", 32'(bus.state), 32'(st));
        check("ctrl", 32'(obs_ctrl()), 32'(e));
        check("pc_en", 32'(bus.pc_en), 32'(pc_exp));
        check("illegal_op", 32'(bus.illegal_op), 32'(st == 1 && !is_legal(op)));
        check("mem_rd_wr_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
        check("rw_pcw_excl", 32'(bus.RegWrite & bus.PCWrite), 32'd0);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        build_path(op, fn);
        foreach (path_q[k]) begin
            check_cycle(path_q[k], op, z);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        reset      = 1'b1;
        bus.opcode = 6'h3f;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0)));
        check("rst_pc_en", 32'(bus.pc_en), 32'd1);
        check("rst_illegal", 32'(bus.illegal_op), 32'd0);

        run_instr(6'h23, 6'h00, 1'b0);   // lw
        run_instr(6'h2b, 6'h00, 1'b0);   // sw
        run_instr(6'h00, 6'h20, 1'b0);   // add
        run_instr(6'h00, 6'h08, 1'b0);   // jr
        run_instr(6'h04, 6'h00, 1'b1);   // beq taken
        run_instr(6'h04, 6'h00, 1'b0);   // beq not taken
        run_instr(6'h05, 6'h00, 1'b1);   // bne not taken
        run_instr(6'h05, 6'h00, 1'b0);   // bne taken
        run_instr(6'h02, 6'h00, 1'b1);   // j
        run_instr(6'h08, 6'h00, 1'b0);   // addi
        run_instr(6'h3f, 6'h00, 1'b0);   // unsupported

        // Reset while in MEMRD abandons the load.
        bus.opcode = 6'h23;
        bus.zero   = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_memrd", 32'(bus.state), 32'd3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midrst_state", 32'(bus.state), 32'd0);
        check("midrst_memread", 32'(bus.MemRead), 32'd1);
        check("midrst_iord", 32'(bus.IorD), 32'd0);
        check("midrst_pc_en", 32'(bus.pc_en), 32'd1);

        for (int i = 0; i < 60; i++) begin
            fn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 8))
                0: op = 6'h23;
                1: op = 6'h2b;
                2: op = 6'h00;
                3: begin op = 6'h00; fn = 6'h08; end
                4: op = 6'h04;
                5: op = 6'h05;
                6: op = 6'h02;
                7: op = 6'h08;
                default: op = 6'($urandom_range(0, 63));
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
